// File: rtl/hardwired_control_unit.sv
// Hardwired control unit: fetches through a Mem_ready handshake, then steps T3..T5
// to drive the DataPath strobes for ALU register-register and register-unary ops.
module hardwired_control_unit #(
   parameter int MEM_TIMEOUT = 15,
   parameter int NUM_REGS    = 16
) (
   input  logic                Clock,
   input  logic                Resetn,
   input  logic                Start,
   input  logic                Stop,
   input  logic                Mem_ready,
   input  logic [31:0]         IR,
   output logic                PCout,
   output logic                Zlowout,
   output logic                MDRout,
   output logic                MARin,
   output logic                Zin,
   output logic                PCin,
   output logic                MDRin,
   output logic                IRin,
   output logic                Yin,
   output logic                IncPC,
   output logic                Read,
   output logic                ADD,
   output logic                SUB,
   output logic                AND,
   output logic                OR,
   output logic                NOT,
   output logic                NEG,
   output logic [NUM_REGS-1:0] Rin,
   output logic [NUM_REGS-1:0] Rout,
   output logic                Run,
   output logic                Fault
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_HALT, ST_FAULT
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);
   localparam logic [NUM_REGS-1:0] ONE_REG = {{(NUM_REGS-1){1'b0}}, 1'b1};

   state_t      state_q, state_d;
   logic [7:0]  wait_count;
   logic        fault_q;
   logic [4:0]  op;
   logic [3:0]  ra, rb, rc;
   logic        is_binary, is_unary;
   logic        alu_drive;

   assign op = IR[31:27];
   assign ra = IR[26:23];
   assign rb = IR[22:19];
   assign rc = IR[18:15];

   assign is_binary = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   assign is_unary  = (op == OP_NEG) || (op == OP_NOT);

   // The wait counter only ever counts inside T1; every T1 entry comes from T0, so clearing there restarts it.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q    <= ST_IDLE;
         wait_count <= 8'd0;
         fault_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_T0)
            wait_count <= 8'd0;
         else if (state_q == ST_T1 && !Mem_ready)
            wait_count <= wait_count + 8'd1;
         if (state_d == ST_FAULT)
            fault_q <= 1'b1;
      end
   end

   // Next-state logic; Mem_ready is checked before the timeout so a late response still wins.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (Start) state_d = ST_T0;
         ST_T0:    state_d = Stop ? ST_HALT : ST_T1;
         ST_T1: begin
            if (Mem_ready)
               state_d = ST_T2;
            else if (wait_count == WAIT_LIMIT)
               state_d = ST_FAULT;
         end
         ST_T2:    state_d = ST_T3;
         ST_T3: begin
            if (is_binary || is_unary)
               state_d = ST_T4;
            else if (op == OP_HALT)
               state_d = ST_HALT;
            else
               state_d = ST_T0;
         end
         ST_T4:    state_d = is_binary ? ST_T5 : ST_T0;
         ST_T5:    state_d = ST_T0;
         ST_HALT:  if (Start) state_d = ST_T0;
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Moore strobe decode from the registered state and IR only.
   always_comb begin
      PCout     = 1'b0;
      Zlowout   = 1'b0;
      MDRout    = 1'b0;
      MARin     = 1'b0;
      Zin       = 1'b0;
      PCin      = 1'b0;
      MDRin     = 1'b0;
      IRin      = 1'b0;
      Yin       = 1'b0;
      IncPC     = 1'b0;
      Read      = 1'b0;
      Rin       = '0;
      Rout      = '0;
      alu_drive = 1'b0;
      unique case (state_q)
         ST_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         ST_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         ST_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         ST_T3: begin
            if (is_binary) begin
               Rout = ONE_REG << rb;
               Yin  = 1'b1;
            end else if (is_unary) begin
               Rout      = ONE_REG << rb;
               alu_drive = 1'b1;
               Zin       = 1'b1;
            end
         end
         ST_T4: begin
            if (is_binary) begin
               Rout      = ONE_REG << rc;
               alu_drive = 1'b1;
               Zin       = 1'b1;
            end else if (is_unary) begin
               Zlowout = 1'b1;
               Rin     = ONE_REG << ra;
            end
         end
         ST_T5: begin
            Zlowout = 1'b1;
            Rin     = ONE_REG << ra;
         end
         default: begin
         end
      endcase
   end

   assign ADD   = alu_drive && (op == OP_ADD);
   assign SUB   = alu_drive && (op == OP_SUB);
   assign AND   = alu_drive && (op == OP_AND);
   assign OR    = alu_drive && (op == OP_OR);
   assign NOT   = alu_drive && (op == OP_NOT);
   assign NEG   = alu_drive && (op == OP_NEG);
   assign Run   = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_FAULT);
   assign Fault = fault_q;

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Table-driven bench for hardwired_control_unit: per-cycle strobe vectors plus
// hand-written reset sequences, with a running one-hot check on Rin/Rout/ALU selects.
module tb_hardwired_control_unit;

   logic        clock = 1'b0;
   logic        resetn;
   logic        start, stop, memReady;
   logic [31:0] ir;
   logic        pcOut, zLowOut, mdrOut, marIn, zIn, pcIn, mdrIn, irIn, yIn, incPc, readMem;
   logic        aluAdd, aluSub, aluAnd, aluOr, aluNot, aluNeg;
   logic [15:0] rin, rout;
   logic        run, fault;
   logic [16:0] strobes;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic        start;
      logic        stop;
      logic        memReady;
      logic [31:0] ir;
      logic [16:0] strobes;
      logic [15:0] rin;
      logic [15:0] rout;
      logic        run;
      logic        fault;
   } vec_t;

   vec_t vecs[$];

   localparam logic [16:0] S_PCOUT   = 17'h1 << 16;
   localparam logic [16:0] S_ZLOWOUT = 17'h1 << 15;
   localparam logic [16:0] S_MDROUT  = 17'h1 << 14;
   localparam logic [16:0] S_MARIN   = 17'h1 << 13;
   localparam logic [16:0] S_ZIN     = 17'h1 << 12;
   localparam logic [16:0] S_PCIN    = 17'h1 << 11;
   localparam logic [16:0] S_MDRIN   = 17'h1 << 10;
   localparam logic [16:0] S_IRIN    = 17'h1 << 9;
   localparam logic [16:0] S_YIN     = 17'h1 << 8;
   localparam logic [16:0] S_INCPC   = 17'h1 << 7;
   localparam logic [16:0] S_READ    = 17'h1 << 6;
   localparam logic [16:0] S_AND     = 17'h1 << 3;
   localparam logic [16:0] S_NOT     = 17'h1 << 1;
   localparam logic [16:0] T0S = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
   localparam logic [16:0] T1S = S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN;
   localparam logic [16:0] T2S = S_MDROUT | S_IRIN;

   localparam logic [31:0] IR_AND  = 32'h28918000;
   localparam logic [31:0] IR_NOT  = {5'b10001, 4'd5, 4'd7, 4'd0, 15'd0};
   localparam logic [31:0] IR_HALT = {5'b11011, 27'd0};
   localparam logic [31:0] IR_BAD  = {5'b11111, 4'd1, 4'd2, 4'd3, 15'd0};

   assign strobes = {pcOut, zLowOut, mdrOut, marIn, zIn, pcIn, mdrIn, irIn, yIn, incPc, readMem,
                     aluAdd, aluSub, aluAnd, aluOr, aluNot, aluNeg};

   hardwired_control_unit #(.MEM_TIMEOUT(15), .NUM_REGS(16)) dut (
      .Clock(clock), .Resetn(resetn), .Start(start), .Stop(stop), .Mem_ready(memReady), .IR(ir),
      .PCout(pcOut), .Zlowout(zLowOut), .MDRout(mdrOut), .MARin(marIn), .Zin(zIn), .PCin(pcIn),
      .MDRin(mdrIn), .IRin(irIn), .Yin(yIn), .IncPC(incPc), .Read(readMem),
      .ADD(aluAdd), .SUB(aluSub), .AND(aluAnd), .OR(aluOr), .NOT(aluNot), .NEG(aluNeg),
      .Rin(rin), .Rout(rout), .Run(run), .Fault(fault)
   );

   always #5 clock = ~clock;

   // Register enables and ALU selects must never have more than one bit set.
   always @(negedge clock) begin
      checks++;
      if (!$onehot0(rin) || !$onehot0(rout) || !$onehot0(strobes[5:0])) begin
         fails++;
         $display("[TB] FAIL onehot: Rin=%h Rout=%h alu=%b (each must have at most one bit set)",
                  rin, rout, strobes[5:0]);
      end
   end

   function automatic vec_t mk(input logic st, input logic sp, input logic mr, input logic [31:0] i,
                               input logic [16:0] s, input logic [15:0] ri, input logic [15:0] ro,
                               input logic rn, input logic f);
      vec_t v;
      v.start = st; v.stop = sp; v.memReady = mr; v.ir = i;
      v.strobes = s; v.rin = ri; v.rout = ro; v.run = rn; v.fault = f;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      start    = v.start;
      stop     = v.stop;
      memReady = v.memReady;
      ir       = v.ir;
   endtask

   task automatic checkOne(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   task automatic checkOutput(input vec_t v, input string tag);
      checkOne({tag, " strobes"}, 32'(strobes), 32'(v.strobes));
      checkOne({tag, " Rin"},     32'(rin),     32'(v.rin));
      checkOne({tag, " Rout"},    32'(rout),    32'(v.rout));
      checkOne({tag, " Run"},     32'(run),     32'(v.run));
      checkOne({tag, " Fault"},   32'(fault),   32'(v.fault));
   endtask

   task automatic runTable(input string name);
      foreach (vecs[k]) begin
         applyStimulus(vecs[k]);
         #1;
         checkOutput(vecs[k], $sformatf("%s row%0d", name, k));
         @(posedge clock);
         #1;
      end
      vecs.delete();
   endtask

   task automatic pushWaits(input int n, input logic mr, input logic [31:0] i);
      for (int k = 0; k < n; k++) vecs.push_back(mk(0, 0, mr, i, T1S, 0, 0, 1, 0));
   endtask

   initial begin
      vec_t zeroVec;
      zeroVec = mk(0, 0, 0, IR_AND, 0, 0, 0, 0, 0);
      resetn = 1'b0; start = 1'b0; stop = 1'b0; memReady = 1'b0; ir = IR_AND;
      #12;
      checkOutput(zeroVec, "reset");
      resetn = 1'b1;
      @(posedge clock);
      #1;

      // AND R1,R2,R3 through all six states, then into a second fetch.
      vecs.push_back(mk(1, 0, 1, IR_AND, 0,                 0,       0,       0, 0));
      vecs.push_back(mk(0, 0, 1, IR_AND, T0S,               0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 1, IR_AND, T1S,               0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 1, IR_AND, T2S,               0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 1, IR_AND, S_YIN,             0,       16'h0004, 1, 0));
      vecs.push_back(mk(0, 0, 1, IR_AND, S_AND | S_ZIN,     0,       16'h0008, 1, 0));
      vecs.push_back(mk(0, 0, 1, IR_AND, S_ZLOWOUT,         16'h0002, 0,      1, 0));
      vecs.push_back(mk(0, 0, 1, IR_AND, T0S,               0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 1, IR_AND, T1S,               0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 1, IR_AND, T2S,               0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 1, IR_AND, S_YIN,             0,       16'h0004, 1, 0));
      runTable("and");

      // Now in T4 of the second AND; drop reset between edges.
      checkOutput(mk(0, 0, 1, IR_AND, S_AND | S_ZIN, 0, 16'h0008, 1, 0), "midop T4");
      #2 resetn = 1'b0;
      #1 checkOutput(zeroVec, "midop reset");
      #2 resetn = 1'b1;
      start = 1'b0;
      @(posedge clock);
      #1 checkOutput(zeroVec, "idle after reset");

      // NOT R5,R7 with a 3-cycle memory wait, then Stop in T0 and resume.
      vecs.push_back(mk(1, 0, 0, IR_NOT, 0,                 0,       0,       0, 0));
      vecs.push_back(mk(0, 0, 0, IR_NOT, T0S,               0,       0,       1, 0));
      pushWaits(3, 0, IR_NOT);
      pushWaits(1, 1, IR_NOT);
      vecs.push_back(mk(0, 0, 0, IR_NOT, T2S,               0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 0, IR_NOT, S_NOT | S_ZIN,     0,       16'h0080, 1, 0));
      vecs.push_back(mk(0, 0, 0, IR_NOT, S_ZLOWOUT,         16'h0020, 0,      1, 0));
      vecs.push_back(mk(0, 1, 0, IR_NOT, T0S,               0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 1, IR_NOT, 0,                 0,       0,       0, 0));
      vecs.push_back(mk(1, 0, 1, IR_NOT, 0,                 0,       0,       0, 0));
      // HALT opcode: halts after T3, resumes on Start.
      vecs.push_back(mk(0, 0, 1, IR_HALT, T0S,              0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 1, IR_HALT, T1S,              0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 1, IR_HALT, T2S,              0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 1, IR_HALT, 0,                0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 1, IR_HALT, 0,                0,       0,       0, 0));
      vecs.push_back(mk(1, 0, 1, IR_HALT, 0,                0,       0,       0, 0));
      // Illegal opcode behaves as NOP: T3 idle, back to T0.
      vecs.push_back(mk(0, 0, 1, IR_BAD, T0S,               0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 1, IR_BAD, T1S,               0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 1, IR_BAD, T2S,               0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 1, IR_BAD, 0,                 0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 0, IR_BAD, T0S,               0,       0,       1, 0));
      // Mem_ready on the last allowed wait cycle beats the timeout.
      pushWaits(14, 0, IR_BAD);
      pushWaits(1, 1, IR_BAD);
      vecs.push_back(mk(0, 0, 0, IR_BAD, T2S,               0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 0, IR_BAD, 0,                 0,       0,       1, 0));
      vecs.push_back(mk(0, 0, 0, IR_BAD, T0S,               0,       0,       1, 0));
      // Memory never answers: 15 wait cycles, then FAULT ignores Start.
      pushWaits(15, 0, IR_BAD);
      vecs.push_back(mk(1, 0, 0, IR_BAD, 0,                 0,       0,       0, 1));
      vecs.push_back(mk(1, 0, 0, IR_BAD, 0,                 0,       0,       0, 1));
      runTable("seq");

      start = 1'b0;
      #2 resetn = 1'b0;
      #1 checkOutput(zeroVec, "fault cleared by reset");
      #2 resetn = 1'b1;
      @(posedge clock);
      #1 checkOutput(zeroVec, "idle after fault reset");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/hardwired_control_unit.md
Name: hardwired_control_unit

Overview:
- Hardwired control unit that generates, cycle by cycle, the DataPath control strobes that are currently driven by hand in benches.
- Fetches an instruction with a memory-ready handshake and decodes IR fields into one-hot register enables.
- Sequences T0..T5 for ALU register-register and register-unary instructions.
- Sits beside DataPath; its outputs connect 1:1 to DataPath control inputs, and it reads IR back from DataPath.

Parameters:
- MEM_TIMEOUT, 15, maximum cycles spent in T1 waiting for Mem_ready before entering FAULT (legal range 1..255).
- NUM_REGS, 16, number of general registers; sets the width of Rin/Rout.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  level; sampled in IDLE to begin execution.
- Stop  in  1  level; sampled at end of T0; when high, go to HALT instead of continuing fetch.
- Mem_ready  in  1  memory has placed data on Mdatain; valid in T1 only.
- IR  in  32  instruction register contents from DataPath.
- PCout, Zlowout, MDRout  out  1 each  bus drive strobes.
- MARin, Zin, PCin, MDRin, IRin, Yin  out  1 each  register load strobes.
- IncPC, Read  out  1 each  ALU PC-increment select; memory read.
- ADD, SUB, AND, OR, NOT, NEG  out  1 each  one-hot ALU operation select.
- Rin  out  NUM_REGS  one-hot general-register load enable.
- Rout  out  NUM_REGS  one-hot general-register bus drive.
- Run  out  1  high whenever state is not IDLE, HALT or FAULT.
- Fault  out  1  sticky; set on memory timeout, cleared only by reset.

Behaviour:
- IR decode:
  - op = IR[31:27]; Ra = IR[26:23]; Rb = IR[22:19]; Rc = IR[18:15].
  - Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, NEG 10000, NOT 10001, HALT 11011. All others are NOP.
  - Example: 32'h28918000 decodes to AND, Ra=1, Rb=2, Rc=3.
- State register: states IDLE, T0, T1, T2, T3, T4, T5, HALT, FAULT.
- Output timing: all outputs are Moore-style, decoded from the registered state plus IR. No output may depend combinationally on Start, Stop or Mem_ready.
- Reset:
  - Resetn low forces state to IDLE and clears the timeout counter and Fault, immediately and regardless of Clock.
  - All strobes, Rin and Rout are 0 while Resetn is low and in IDLE.
  - Reset mid-instruction abandons the instruction; no strobe is asserted after Resetn falls.
- IDLE: all outputs 0. Go to T0 when Start=1.
- T0: PCout, MARin, IncPC, Zin. Go to HALT if Stop=1, else T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Stay in T1 while Mem_ready=0; strobes stay asserted during the wait.
  - Timeout counter clears on T1 entry and increments each T1 cycle with Mem_ready=0.
  - If the count reaches MEM_TIMEOUT, go to FAULT and set Fault.
  - Mem_ready=1 goes to T2, taking priority over a timeout in the same cycle.
  - PCin is asserted every cycle in T1 (PC reload is idempotent because Z is held).
- T2: MDRout, IRin. Always go to T3; IR is valid from T3 onward.
- T3, by opcode:
  - ADD/SUB/AND/OR: Rout[Rb], Yin; next T4.
  - NEG/NOT: Rout[Rb], op strobe, Zin; next T4.
  - HALT: no strobes; next HALT.
  - NOP: no strobes; next T0.
- T4, by opcode:
  - ADD/SUB/AND/OR: Rout[Rc], op strobe, Zin; next T5.
  - NEG/NOT: Zlowout, Rin[Ra]; next T0.
- T5 (binary ops only): Zlowout, Rin[Ra]; next T0.
- Rin/Rout invariants:
  - Never more than one bit set; all zero outside the states listed above.
  - Ra=Rb (e.g. AND R1,R1,R1) needs no special case, because read and write occur in different states.
- HALT: outputs 0 and Run=0. Leaves only when Start=1, going to T0, so execution resumes from the current PC.
- FAULT: outputs 0, Run=0, Fault=1. Held until reset.
- Steady-state instruction latency:
  - Binary ops: 6 cycles plus Mem_ready wait.
  - Unary ops: 5 cycles plus wait.
  - NOP: 4 cycles plus wait.

Test Plan:
- Reset mid-op: reset, Start=1, Mem_ready=1, IR=32'h28918000 → per-cycle strobes exactly as follows, then back in T0:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T3: Rout=16'h0004, Yin.
  - T4: Rout=16'h0008, AND, Zin.
  - T5: Zlowout, Rin=16'h0002.
  - Then assert Resetn=0 mid-T4: all outputs 0 within the same cycle and state is IDLE.
- Mem_ready waits: Mem_ready low for 3 cycles, then high → T1 strobes held for 4 cycles, then T2, no Fault; repeat with Mem_ready never high → FAULT after exactly MEM_TIMEOUT=15 wait cycles, Fault=1, Run=0, all strobes 0; Start has no effect.
- NOT R5,R7 (IR op 10001, Ra=5, Rb=7) → T3: Rout=16'h0080, NOT, Zin. T4: Zlowout, Rin=16'h0020. Next state T0.
- HALT opcode → after T3, Run=0 and outputs idle; Start pulse → T0 with PCout asserted. Separately, Stop=1 during T0 → HALT next cycle and no Read is issued.
- Illegal opcode 11111 → T3 has no strobes, then T0; Rin/Rout remain 0 throughout; one-hot checker on Rin, Rout and the ALU selects passes for the whole run.
